sched_ready_tracker: RTL
========================

// Module: sched_ready_tracker
// PURPOSE
//  Per-commit-slot readiness tracker directly upstream of the ALU scheduler.
//  Rename allocates an entry per instruction with unit class and up to 2 in-flight producer deps.
//  Writeback wakes dependants; scheduler grants clear entries.
//  Emits per-unit-class ready bitmaps rotated head-relative (bit 0 = oldest) for the scheduler's priority pick.
// PARAMETERS
//  NCOMMIT   32  commit slots (power of 2)
//  LNCOMMIT  5   log2(NCOMMIT)
//  NRENAME   4   allocation lanes per cycle
//  NWB       4   writeback wakeup lanes per cycle
//  UW        3   unit-class code width
// PORTS
//  clk            in   1                 clock
//  reset          in   1                 async, active-low
//  alloc_valid    in   NRENAME           lane allocates entry
//  alloc_idx      in   NRENAME*LNCOMMIT  commit slot per lane
//  alloc_unit     in   NRENAME*UW        unit class (0 ALU,1 SHIFT,2 MUL,3 LOAD,4 STORE,5 BRANCH,6 FPU)
//  alloc_dep_v    in   NRENAME*2         dep rs1/rs2 on in-flight producer
//  alloc_dep_idx  in   NRENAME*2*LNCOMMIT producer slot per dep
//  wb_valid       in   NWB               result written back
//  wb_idx         in   NWB*LNCOMMIT      producer slot
//  issue_mask     in   NCOMMIT           scheduler grants, absolute slot order
//  commit_mask    in   NCOMMIT           slots retired this cycle
//  flush_mask     in   NCOMMIT           slots killed (mispredict/trap)
//  commit_head    in   LNCOMMIT          oldest live slot
//  ready_out      out  7*NCOMMIT         per-class ready bitmap, head-relative, class c at [c*NCOMMIT+:NCOMMIT]
//  busy           out  1                 any entry WAIT or READY
//  err_realloc    out  1                 pulse: alloc hit non-IDLE slot
// BEHAVIOUR
//  Reset (reset low, async): every entry IDLE, ready_out=0, busy=0, err_realloc=0.
//  Entry state IDLE/WAIT/READY/ISSUED; per entry: unit[UW], dep_v[2], dep_idx[2].
//  IDLE->READY on alloc with no pending dep; IDLE->WAIT otherwise.
//  WAIT->READY when last pending dep cleared; dep bit clears when any wb lane idx==dep_idx.
//  READY->ISSUED on issue_mask bit; ISSUED->IDLE on commit_mask bit.
//  Any state->IDLE on flush_mask bit.
//  Same-cycle bypass: alloc dep matching a wb lane that cycle is born cleared.
//  Alloc with all deps cleared by bypass -> READY.
//  Priority per entry: flush > alloc > issue > wakeup.
//  Issue and wakeup same cycle -> ISSUED. Issue on non-READY entry ignored.
//  commit on non-ISSUED entry ignored.
//  Wakeup for a slot not WAIT is harmless (only compares dep_idx in WAIT entries).
//  Alloc on non-IDLE slot overwrites; err_realloc=1 next cycle.
//  Two lanes same idx: highest lane wins, err_realloc=1.
//  ready_out registered: computed from next-state, rotated by commit_head sampled same edge.
//  Bit i = slot (commit_head+i) mod NCOMMIT; wrap by LNCOMMIT-bit add.
//  Latency 1: alloc/wake at N -> ready visible N+1; issue at N -> bit clear N+1 (no double grant).
//  busy registered alongside ready_out.
//  Reset asserted mid-operation clears all state immediately; first alloc accepted at first edge after release.
// STRUCTURE
//  Package sched_pkg: unit_class_t enum (UW bits), entry_state_t enum, NUNIT_CLASS=7.
//  Sub-module sched_ready_entry (one per slot, generate loop): state FSM, dep compare vs NWB lanes.
//  Top: per-slot alloc lane select/bypass, class decode, head rotation of 7 bitmaps, error flag.
// TESTING
//  1. Alloc slot 5 unit ALU no deps, head=0 -> cycle+1 ready_out[0*32+5]=1; issue_mask[5] -> next cycle 0.
//  2. Alloc slot 9 MUL dep on 3; wb_idx=3 two cycles later -> slot 9 ready exactly the cycle after wb.
//  3. Head=30, slots 31 and 1 LOAD ready -> LOAD bitmap bits 1 and 3 set (wrap).
//  4. Alloc slot 4 dep on 2 with wb_idx=2 same cycle -> ready next cycle; flush+alloc slot 4 same cycle -> IDLE.
//  5. Lanes 0,2 both alloc slot 7 -> lane 2 unit kept, err_realloc pulses 1 cycle.
//  6. Reset low mid-run with 10 WAIT entries -> ready_out=0, busy=0 without clock; resume clean alloc.

Source files
------------

// File: rtl/sched_pkg.sv
// Shared types and sizing for the scheduler readiness tracker.
// The wb_hit helper is the single definition of a writeback match, used by the entries and by the alloc bypass.
package sched_pkg;

   localparam int NCOMMIT     = 32;
   localparam int LNCOMMIT    = 5;
   localparam int NRENAME     = 4;
   localparam int NWB         = 4;
   localparam int UW          = 3;
   localparam int NUNIT_CLASS = 7;

   typedef enum logic [UW-1:0] {
      UNIT_ALU    = 3'd0,
      UNIT_SHIFT  = 3'd1,
      UNIT_MUL    = 3'd2,
      UNIT_LOAD   = 3'd3,
      UNIT_STORE  = 3'd4,
      UNIT_BRANCH = 3'd5,
      UNIT_FPU    = 3'd6
   } unit_class_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WAIT   = 2'd1,
      ST_READY  = 2'd2,
      ST_ISSUED = 2'd3
   } entry_state_t;

   // True when any valid writeback lane carries the given producer slot.
   function automatic logic wb_hit(input logic [NWB-1:0]          v,
                                   input logic [NWB*LNCOMMIT-1:0] idx,
                                   input logic [LNCOMMIT-1:0]     slot);
      logic hit;
      hit = 1'b0;
      for (int w = 0; w < NWB; w++) begin
         if (v[w] && (idx[w*LNCOMMIT +: LNCOMMIT] == slot)) hit = 1'b1;
      end
      return hit;
   endfunction

endpackage

// File: rtl/sched_ready_entry.sv
// One commit-slot readiness entry: lifecycle FSM plus two producer-dependency trackers.
//
//   state     | meaning
//   ----------+-----------------------------------------------
//   ST_IDLE   | slot free
//   ST_WAIT   | allocated, at least one producer still pending
//   ST_READY  | all operands available, eligible for issue
//   ST_ISSUED | granted by scheduler, waiting for commit
module sched_ready_entry
   import sched_pkg::*;
(
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      alloc,
   input  logic [UW-1:0]             alloc_unit,
   input  logic [1:0]                alloc_dep_v,
   input  logic [2*LNCOMMIT-1:0]     alloc_dep_idx,
   input  logic [NWB-1:0]            wb_valid,
   input  logic [NWB*LNCOMMIT-1:0]   wb_idx,
   input  logic                      issue,
   input  logic                      commit,
   input  logic                      flush,
   output logic                      idle,
   output logic                      ready_nxt,
   output logic                      busy_nxt,
   output logic [UW-1:0]             unit_nxt
);

   entry_state_t              state_q, state_d;
   unit_class_t               unit_q, unit_d;
   logic [1:0]                dep_v_q, dep_v_d;
   logic [2*LNCOMMIT-1:0]     dep_idx_q, dep_idx_d;
   logic [1:0]                dep_hit;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         unit_q    <= UNIT_ALU;
         dep_v_q   <= '0;
         dep_idx_q <= '0;
      end else begin
         state_q   <= state_d;
         unit_q    <= unit_d;
         dep_v_q   <= dep_v_d;
         dep_idx_q <= dep_idx_d;
      end
   end

   always_comb begin
      dep_hit[0] = wb_hit(wb_valid, wb_idx, dep_idx_q[0 +: LNCOMMIT]);
      dep_hit[1] = wb_hit(wb_valid, wb_idx, dep_idx_q[LNCOMMIT +: LNCOMMIT]);
   end

   // Priority: flush > alloc > issue/commit > wakeup.
   always_comb begin
      state_d   = state_q;
      unit_d    = unit_q;
      dep_v_d   = dep_v_q;
      dep_idx_d = dep_idx_q;
      if (flush) begin
         state_d = ST_IDLE;
         dep_v_d = '0;
      end else if (alloc) begin
         unit_d    = unit_class_t'(alloc_unit);
         dep_v_d   = alloc_dep_v;
         dep_idx_d = alloc_dep_idx;
         state_d   = (|alloc_dep_v) ? ST_WAIT : ST_READY;
      end else begin
         case (state_q)
            ST_WAIT: begin
               dep_v_d = dep_v_q & ~dep_hit;
               if (~|(dep_v_q & ~dep_hit)) state_d = ST_READY;
            end
            ST_READY:  if (issue)  state_d = ST_ISSUED;
            ST_ISSUED: if (commit) state_d = ST_IDLE;
            default: ;
         endcase
      end
   end

   assign idle      = (state_q == ST_IDLE);
   assign ready_nxt = (state_d == ST_READY);
   assign busy_nxt  = (state_d == ST_READY) || (state_d == ST_WAIT);
   assign unit_nxt  = unit_d;

endmodule

// File: rtl/sched_ready_tracker.sv
// Per-slot readiness tracker feeding the ALU scheduler: alloc lane steering with writeback bypass,
// per-class ready bitmaps rotated so bit 0 is the oldest slot, and a realloc error pulse.
module sched_ready_tracker
   import sched_pkg::*;
(
   input  logic                               clk,
   input  logic                               reset,
   input  logic [NRENAME-1:0]                 alloc_valid,
   input  logic [NRENAME*LNCOMMIT-1:0]        alloc_idx,
   input  logic [NRENAME*UW-1:0]              alloc_unit,
   input  logic [NRENAME*2-1:0]               alloc_dep_v,
   input  logic [NRENAME*2*LNCOMMIT-1:0]      alloc_dep_idx,
   input  logic [NWB-1:0]                     wb_valid,
   input  logic [NWB*LNCOMMIT-1:0]            wb_idx,
   input  logic [NCOMMIT-1:0]                 issue_mask,
   input  logic [NCOMMIT-1:0]                 commit_mask,
   input  logic [NCOMMIT-1:0]                 flush_mask,
   input  logic [LNCOMMIT-1:0]                commit_head,
   output logic [NUNIT_CLASS*NCOMMIT-1:0]     ready_out,
   output logic                               busy,
   output logic                               err_realloc
);

   logic [NRENAME*2-1:0]           lane_dep_v;
   logic [NCOMMIT-1:0]             slot_alloc;
   logic [NCOMMIT-1:0]             slot_idle;
   logic [NCOMMIT-1:0]             slot_ready_nxt;
   logic [NCOMMIT-1:0]             slot_busy_nxt;
   logic [NCOMMIT-1:0][UW-1:0]     slot_unit_nxt;
   logic [NUNIT_CLASS*NCOMMIT-1:0] ready_d;
   logic [LNCOMMIT-1:0]            rot_slot;
   logic                           err_d;

   // A dependency whose producer writes back in the allocation cycle is born satisfied.
   always_comb begin
      lane_dep_v = '0;
      for (int l = 0; l < NRENAME; l++) begin
         for (int d = 0; d < 2; d++) begin
            lane_dep_v[l*2+d] = alloc_dep_v[l*2+d] &&
               !wb_hit(wb_valid, wb_idx, alloc_dep_idx[(l*2+d)*LNCOMMIT +: LNCOMMIT]);
         end
      end
   end

   for (genvar s = 0; s < NCOMMIT; s++) begin : g_slot
      logic                  sel;
      logic [UW-1:0]         sel_unit;
      logic [1:0]            sel_dep_v;
      logic [2*LNCOMMIT-1:0] sel_dep_idx;

      // Ascending scan so the highest-numbered lane targeting this slot wins.
      always_comb begin
         sel         = 1'b0;
         sel_unit    = '0;
         sel_dep_v   = '0;
         sel_dep_idx = '0;
         for (int l = 0; l < NRENAME; l++) begin
            if (alloc_valid[l] && (alloc_idx[l*LNCOMMIT +: LNCOMMIT] == LNCOMMIT'(s))) begin
               sel         = 1'b1;
               sel_unit    = alloc_unit[l*UW +: UW];
               sel_dep_v   = lane_dep_v[l*2 +: 2];
               sel_dep_idx = alloc_dep_idx[l*2*LNCOMMIT +: 2*LNCOMMIT];
            end
         end
      end

      assign slot_alloc[s] = sel;

      sched_ready_entry u_entry (
         .clk           (clk),
         .reset         (reset),
         .alloc         (sel),
         .alloc_unit    (sel_unit),
         .alloc_dep_v   (sel_dep_v),
         .alloc_dep_idx (sel_dep_idx),
         .wb_valid      (wb_valid),
         .wb_idx        (wb_idx),
         .issue         (issue_mask[s]),
         .commit        (commit_mask[s]),
         .flush         (flush_mask[s]),
         .idle          (slot_idle[s]),
         .ready_nxt     (slot_ready_nxt[s]),
         .busy_nxt      (slot_busy_nxt[s]),
         .unit_nxt      (slot_unit_nxt[s])
      );
   end

   always_comb begin
      ready_d  = '0;
      rot_slot = '0;
      for (int i = 0; i < NCOMMIT; i++) begin
         rot_slot = commit_head + LNCOMMIT'(i);
         for (int c = 0; c < NUNIT_CLASS; c++) begin
            ready_d[c*NCOMMIT+i] = slot_ready_nxt[rot_slot] && (slot_unit_nxt[rot_slot] == UW'(c));
         end
      end
   end

   always_comb begin
      err_d = 1'b0;
      for (int s = 0; s < NCOMMIT; s++) begin
         if (slot_alloc[s] && !slot_idle[s]) err_d = 1'b1;
      end
      for (int i = 0; i < NRENAME; i++) begin
         for (int j = i + 1; j < NRENAME; j++) begin
            if (alloc_valid[i] && alloc_valid[j] &&
                (alloc_idx[i*LNCOMMIT +: LNCOMMIT] == alloc_idx[j*LNCOMMIT +: LNCOMMIT]))
               err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ready_out   <= '0;
         busy        <= 1'b0;
         err_realloc <= 1'b0;
      end else begin
         ready_out   <= ready_d;
         busy        <= |slot_busy_nxt;
         err_realloc <= err_d;
      end
   end

endmodule
